// File: rtl/lzx_seg_scan_ctrl_if.sv
// rtl/lzx_seg_scan_ctrl_if.sv - write port bundle for the multiplexed digit scanner
interface lzx_seg_scan_ctrl_if #(
  parameter int N_DIG = 4
);
  logic                 wr_en;
  logic [4*N_DIG-1:0]   wr_data;
  logic                 wr_ready;

  modport master (output wr_en, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_data, output wr_ready);
endinterface

// File: rtl/lzx_seg_scan_ctrl.sv
// rtl/lzx_seg_scan_ctrl.sv - N-digit scanner driving a 74HC4511 with gap blanking and frame-aligned commits
module lzx_seg_scan_ctrl #(
  parameter int N_DIG = 4,
  parameter int DWELL = 1000,
  parameter int GAP   = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  lzx_seg_scan_ctrl_if.slave wr,
  input  logic               blank_lz,
  input  logic               lt_req,
  output logic [3:0]         D,
  output logic               LE,
  output logic               BI_n,
  output logic               LT_n,
  output logic [N_DIG-1:0]   dig_sel,
  output logic               frame_done
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [4*N_DIG-1:0] active;
  logic [4*N_DIG-1:0] pending;
  logic               pend_valid;
  logic [N_DIG-1:0]   zero_from;
  logic [N_DIG-1:0]   blank_vec;

  function automatic logic [3:0] digit(input logic [4*N_DIG-1:0] v, input int i);
    return v[4*i +: 4];
  endfunction

  assign wr.wr_ready = !pend_valid;

  // zero_from[i]: every active digit from the MSD down to i is zero
  always_comb begin
    zero_from = '0;
    zero_from[N_DIG-1] = (digit(active, N_DIG-1) == 4'd0);
    for (int i = N_DIG-2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (digit(active, i) == 4'd0);
    end
  end

  // lt_req feeds blanking directly so BI_n lines up with the registered LT_n
  assign blank_vec = zero_from & ~N_DIG'(1) & {N_DIG{blank_lz & ~lt_req}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_GAP;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      D          <= 4'd0;
      LE         <= 1'b0;
      BI_n       <= 1'b0;
      LT_n       <= 1'b1;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      LT_n       <= !lt_req;
      frame_done <= 1'b0;

      if (wr.wr_en && !pend_valid) begin
        pending    <= wr.wr_data;
        pend_valid <= 1'b1;
      end

      case (state)
        ST_GAP: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            state <= ST_LATCH;
            cnt   <= '0;
            LE    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LATCH: begin
          state   <= ST_SHOW;
          cnt     <= '0;
          dig_sel <= N_DIG'(1) << idx;
          BI_n    <= !blank_vec[idx];
        end

        ST_SHOW: begin
          if (cnt == CNT_W'(DWELL - 1)) begin
            state   <= ST_GAP;
            cnt     <= '0;
            LE      <= 1'b0;
            BI_n    <= 1'b0;
            dig_sel <= '0;
            if (idx == IDX_W'(N_DIG - 1)) begin
              // frame boundary: commit so the new word is already on D in the first gap cycle
              idx        <= '0;
              frame_done <= 1'b1;
              if (pend_valid) begin
                active     <= pending;
                pend_valid <= 1'b0;
                D          <= digit(pending, 0);
              end else begin
                D <= digit(active, 0);
              end
            end else begin
              idx <= idx + 1'b1;
              D   <= digit(active, int'(idx) + 1);
            end
          end else begin
            cnt  <= cnt + 1'b1;
            BI_n <= !blank_vec[idx];
          end
        end

        default: begin
          state <= ST_GAP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzx_seg_scan_ctrl.sv
// tb/tb_lzx_seg_scan_ctrl.sv - scoreboard bench for the digit scanner (N_DIG=4, DWELL=4, GAP=2)
module tb_lzx_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int GP    = 2;
  localparam int FRAME = N * (GP + 1 + DW);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           blank_lz = 1'b0;
  logic           lt_req = 1'b0;
  logic [3:0]     D;
  logic           LE, BI_n, LT_n, frame_done;
  logic [N-1:0]   dig_sel;

  lzx_seg_scan_ctrl_if #(.N_DIG(N)) wif ();

  lzx_seg_scan_ctrl #(.N_DIG(N), .DWELL(DW), .GAP(GP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wr(wif.slave), .blank_lz(blank_lz), .lt_req(lt_req),
    .D(D), .LE(LE), .BI_n(BI_n), .LT_n(LT_n), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] d;
    logic       bi;
    logic       ltn;
  } win_t;

  win_t exp_q[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] val, input logic [3:0] bi, input logic ltn);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back('{sel: 4'(1 << i), d: val[4*i +: 4], bi: bi[i], ltn: ltn});
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    checks++;
    if (!frame_done) begin
      errs++;
      $display("FAIL frame_done_timeout: got none expected pulse within 100 cycles");
    end
  endtask

  task automatic do_write(input logic [15:0] v, input logic exp_rdy);
    @(negedge clk);
    chk("wr_ready", 32'(wif.wr_ready), 32'(exp_rdy));
    #1;
    wif.wr_en   = 1'b1;
    wif.wr_data = v;
    @(negedge clk);
    #1;
    wif.wr_en = 1'b0;
  endtask

  // Monitor: pops one expectation per SHOW window and checks scan timing
  int         cyc, len, le_cnt;
  logic       in_win, le_valid, first_win;
  logic [3:0] win_d;
  logic [N-1:0] win_sel;
  win_t       w;

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; len = 0; le_cnt = 0;
      in_win = 1'b0; le_valid = 1'b0; first_win = 1'b1;
    end else begin
      cyc++;
      if (LE) le_cnt++;
      if (frame_done) begin
        chk("frame_period", 32'(cyc), 32'(FRAME));
        cyc = 0;
      end
      if (dig_sel != '0 && !in_win) begin
        if (first_win) begin
          chk("first_show_latency", 32'(cyc), 32'(GP + 1));
          first_win = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_window: got dig_sel=%b expected no window", dig_sel);
        end else begin
          w = exp_q.pop_front();
          chk("win_sel", 32'(dig_sel), 32'(w.sel));
          chk("win_d", 32'(D), 32'(w.d));
          chk("win_bi_n", 32'(BI_n), 32'(w.bi));
          chk("win_lt_n", 32'(LT_n), 32'(w.ltn));
          chk("win_le", 32'(LE), 32'd1);
        end
        in_win  = 1'b1;
        len     = 1;
        win_d   = D;
        win_sel = dig_sel;
      end else if (in_win && dig_sel != '0) begin
        len++;
        chk("d_stable", 32'(D), 32'(win_d));
        chk("sel_stable", 32'(dig_sel), 32'(win_sel));
      end else if (in_win) begin
        chk("show_len", 32'(len), 32'(DW));
        if (le_valid) chk("le_per_digit", 32'(le_cnt), 32'(1 + DW));
        le_cnt   = 0;
        le_valid = 1'b1;
        in_win   = 1'b0;
      end
      if (dig_sel == '0) chk("bi_n_blank_outside_show", 32'(BI_n), 32'd0);
    end
  end

  initial begin
    int n;
    wif.wr_en   = 1'b0;
    wif.wr_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_d", 32'(D), 32'd0);
    chk("rst_le", 32'(LE), 32'd0);
    chk("rst_bi_n", 32'(BI_n), 32'd0);
    chk("rst_lt_n", 32'(LT_n), 32'd1);
    chk("rst_dig_sel", 32'(dig_sel), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_wr_ready", 32'(wif.wr_ready), 32'd1);
    push_frame(16'h0000, 4'b1111, 1'b1);
    #1 rst = 1'b0;

    // frame 1: still blank word; 0x1234 queued mid-frame
    wait_fd();
    push_frame(16'h0000, 4'b1111, 1'b1);
    do_write(16'h1234, 1'b1);

    // frame 2: 1234 shown; second write while pending must be dropped
    wait_fd();
    push_frame(16'h1234, 4'b1111, 1'b1);
    do_write(16'h1111, 1'b1);
    repeat (8) @(negedge clk);
    do_write(16'h2222, 1'b0);

    wait_fd();
    push_frame(16'h1111, 4'b1111, 1'b1);
    @(negedge clk);
    chk("wr_ready_after_commit", 32'(wif.wr_ready), 32'd1);
    #1 blank_lz = 1'b1;
    do_write(16'h0050, 1'b1);

    // leading-zero blanking of 0050, then 0000
    wait_fd();
    push_frame(16'h0050, 4'b0011, 1'b1);
    do_write(16'h0000, 1'b1);

    wait_fd();
    push_frame(16'h0000, 4'b0001, 1'b1);
    do_write(16'h0050, 1'b1);

    // lamp test overrides blanking
    wait_fd();
    chk("lt_n_before_req", 32'(LT_n), 32'd1);
    push_frame(16'h0050, 4'b1111, 1'b0);
    #1 lt_req = 1'b1;
    @(negedge clk);
    chk("lt_n_one_cycle", 32'(LT_n), 32'd0);

    wait_fd();
    push_frame(16'h0050, 4'b0011, 1'b1);
    #1 lt_req = 1'b0;
    do_write(16'h9876, 1'b1);

    // reset mid-SHOW of digit 2 with a write pending
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig_sel != 4'b0100 && n < 100);
    chk("reach_digit2", 32'(dig_sel), 32'b0100);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_d", 32'(D), 32'd0);
    chk("async_rst_le", 32'(LE), 32'd0);
    chk("async_rst_bi_n", 32'(BI_n), 32'd0);
    chk("async_rst_lt_n", 32'(LT_n), 32'd1);
    chk("async_rst_dig_sel", 32'(dig_sel), 32'd0);
    chk("async_rst_wr_ready", 32'(wif.wr_ready), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_frame(16'h0000, 4'b0001, 1'b1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_d", 32'(D), 32'd0);

    wait_fd();
    push_frame(16'h0000, 4'b0001, 1'b1);
    wait_fd();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    errs++;
    checks++;
    $display("FAIL global_timeout: got no completion expected finish before 100000");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
